// File: rtl/kill_reset_ctrl.sv
// kill_reset_ctrl: stretches kill events into CPU resets, logs the first violation cause, counts episodes (optional lockout: KILL_LOCKOUT_EN)
module kill_reset_ctrl #(
  parameter int          HOLD_CYCLES    = 16,
  parameter int          WAIT_MAX       = 256,
  parameter logic [15:0] RESET_HANDLER  = 16'hFFFE,
  parameter int          CNT_W          = 8,
  parameter int          LOCK_THRESHOLD = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             kill_in,
  input  logic [15:0]      pc,
  input  logic [15:0]      data_addr,
  input  logic             r_en,
  input  logic             w_en,
  input  logic             log_clr,
  output logic             cpu_rst,
  output logic [CNT_W-1:0] viol_cnt,
  output logic [15:0]      last_pc,
  output logic [15:0]      last_addr,
  output logic [1:0]       last_acc,
  output logic             log_valid,
  output logic             locked
);
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int WW = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
  localparam logic [HW-1:0] HOLD_LD = HW'(HOLD_CYCLES - 1);
  localparam logic [WW-1:0] WAIT_LD = WW'(WAIT_MAX - 1);
  localparam logic [1:0] S_IDLE = 2'd0, S_HOLD = 2'd1, S_WAIT = 2'd2, S_LOCK = 2'd3;
  if (HOLD_CYCLES < 1 || WAIT_MAX < 1 || LOCK_THRESHOLD < 1) begin : g_bad_param
    $error("kill_reset_ctrl: HOLD_CYCLES, WAIT_MAX and LOCK_THRESHOLD must be >= 1");
  end
  logic [1:0]       r_state, w_nstate;
  logic             r_kill_q, r_cpu_rst, r_locked, r_lv;
  logic [HW-1:0]    r_hold;
  logic [WW-1:0]    r_wait;
  logic [CNT_W-1:0] r_cnt, w_cnt_nx;
  logic [15:0]      r_pc, r_addr;
  logic [1:0]       r_acc;
  logic             w_rise, w_start, w_home, w_lock, w_cap;
  // episode start detection and next-state selection; a kill edge outranks a reset-handler fetch
  always_comb begin
    w_rise   = kill_in & ~r_kill_q;
    w_start  = w_rise & (r_state == S_IDLE || r_state == S_WAIT);
    w_home   = (pc == RESET_HANDLER) & ~kill_in;
    w_cnt_nx = &r_cnt ? r_cnt : r_cnt + 1'b1;
    w_cap    = w_start & ~r_lv;
`ifdef KILL_LOCKOUT_EN
    w_lock   = w_start & (w_cnt_nx >= CNT_W'(LOCK_THRESHOLD));
`else
    w_lock   = 1'b0;
`endif
    w_nstate = (r_state == S_LOCK) ? S_LOCK :
               w_lock ? S_LOCK :
               w_start ? S_HOLD :
               (r_state == S_HOLD && !w_rise && r_hold == '0) ? S_WAIT :
               (r_state == S_WAIT && w_home) ? S_IDLE :
               (r_state == S_WAIT && r_wait == '0) ? S_HOLD : r_state;
  end
  // state, edge detector and registered reset/lock outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_kill_q  <= 1'b0;
      r_cpu_rst <= 1'b0;
      r_locked  <= 1'b0;
    end else begin
      r_state   <= w_nstate;
      r_kill_q  <= kill_in;
      r_cpu_rst <= (w_nstate == S_HOLD) || (w_nstate == S_LOCK);
      r_locked  <= (w_nstate == S_LOCK);
    end
  end
  // hold and wait countdowns; hold reloads on entry and on a retrigger inside HOLD
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold <= '0;
      r_wait <= '0;
    end else begin
      if (w_nstate == S_HOLD && (r_state != S_HOLD || w_rise)) r_hold <= HOLD_LD;
      else if (r_state == S_HOLD && r_hold != '0) r_hold <= r_hold - 1'b1;
      if (r_state == S_HOLD && w_nstate == S_WAIT) r_wait <= WAIT_LD;
      else if (r_state == S_WAIT && r_wait != '0) r_wait <= r_wait - 1'b1;
    end
  end
  // episode counter and first-cause log; a capture beats a simultaneous clear
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_lv   <= 1'b0;
      r_pc   <= '0;
      r_addr <= '0;
      r_acc  <= '0;
    end else begin
      if (w_start) r_cnt <= w_cnt_nx;
      if (w_cap) begin
        r_lv   <= 1'b1;
        r_pc   <= pc;
        r_addr <= data_addr;
        r_acc  <= {w_en, r_en};
      end else if (log_clr && r_state != S_LOCK) begin
        r_lv   <= 1'b0;
        r_pc   <= '0;
        r_addr <= '0;
        r_acc  <= '0;
      end
    end
  end
  assign cpu_rst   = r_cpu_rst;
  assign locked    = r_locked;
  assign viol_cnt  = r_cnt;
  assign last_pc   = r_pc;
  assign last_addr = r_addr;
  assign last_acc  = r_acc;
  assign log_valid = r_lv;
endmodule

// File: tb/tb_kill_reset_ctrl.sv
// tb_kill_reset_ctrl: vector table, directed episode sequences and random run against a cycle-count reference model
module tb_kill_reset_ctrl;
  localparam int HOLD = 16, WAITN = 256;
  logic clk = 1'b0;
  logic rst = 1'b0, kill_in = 1'b0, r_en = 1'b0, w_en = 1'b0, log_clr = 1'b0;
  logic [15:0] pc = '0, data_addr = '0;
  logic cpu_rst, log_valid, locked;
  logic [7:0] viol_cnt;
  logic [15:0] last_pc, last_addr;
  logic [1:0] last_acc;
  int n_tests = 0, n_fail = 0;
  always #5 clk = ~clk;
  kill_reset_ctrl dut (
    .clk(clk), .rst(rst), .kill_in(kill_in), .pc(pc), .data_addr(data_addr),
    .r_en(r_en), .w_en(w_en), .log_clr(log_clr), .cpu_rst(cpu_rst), .viol_cnt(viol_cnt),
    .last_pc(last_pc), .last_addr(last_addr), .last_acc(last_acc), .log_valid(log_valid), .locked(locked)
  );
  // reference: reset cycles left, wait budget left, episode count, log contents
  int m_left, m_wleft, m_cnt;
  bit m_wait, m_kq, m_lv;
  logic [15:0] m_pc, m_addr;
  logic [1:0] m_acc;
  task automatic model();
    bit rise, start;
    rise = kill_in && !m_kq;
    start = 0;
    if (rst) begin
      m_left = 0; m_wait = 0; m_wleft = 0; m_cnt = 0; m_kq = 0;
      m_lv = 0; m_pc = 0; m_addr = 0; m_acc = 0;
    end else begin
      if (m_left > 0) begin
        if (rise) m_left = HOLD;
        else begin
          m_left--;
          if (m_left == 0) begin m_wait = 1; m_wleft = WAITN; end
        end
      end else if (m_wait) begin
        if (pc == 16'hFFFE && !kill_in) m_wait = 0;
        else if (rise) start = 1;
        else begin
          m_wleft--;
          if (m_wleft == 0) begin m_wait = 0; m_left = HOLD; end
        end
      end else start = rise;
      if (start) begin
        m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
        m_left = HOLD;
        m_wait = 0;
      end
      if (start && !m_lv) begin
        m_lv = 1; m_pc = pc; m_addr = data_addr; m_acc = {w_en, r_en};
      end else if (log_clr) begin
        m_lv = 0; m_pc = 0; m_addr = 0; m_acc = 0;
      end
      m_kq = kill_in;
    end
  endtask
  function automatic logic [44:0] dut_vec();
    return {cpu_rst, viol_cnt, log_valid, last_pc, last_addr, last_acc, locked};
  endfunction
  task automatic chk(input string nm, input logic [44:0] act, input logic [44:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic step(input logic r, input logic k, input logic [15:0] p, input logic [15:0] a,
                      input logic re, input logic we, input logic lc);
    rst = r; kill_in = k; pc = p; data_addr = a; r_en = re; w_en = we; log_clr = lc;
    @(posedge clk);
    model();
    #1;
    chk("model", dut_vec(), {m_left > 0, 8'(m_cnt), m_lv, m_pc, m_addr, m_acc, 1'b0});
  endtask
  task automatic idle(input logic [15:0] p);
    step(0, 0, p, 16'h0, 0, 0, 0);
  endtask
  task automatic run_hi(output int hi);
    hi = 0;
    for (int i = 0; i < 400 && cpu_rst; i++) begin hi++; idle(16'h0); end
  endtask
  task automatic run_lo(output int lo);
    lo = 0;
    for (int i = 0; i < 400 && !cpu_rst; i++) begin lo++; idle(16'h0); end
  endtask
  task automatic episode(input logic [15:0] p, input logic [15:0] a);
    step(0, 1, p, a, 1, 0, 0);
    for (int i = 0; i < 18; i++) idle(16'hFFFE);
  endtask
  typedef struct {
    logic r, k; logic [15:0] p, a; logic re, we, lc;
    logic e_rst; logic [7:0] e_cnt; logic e_lv; logic [15:0] e_pc, e_addr; logic [1:0] e_acc;
  } vec_t;
  vec_t tbl[8];
  initial begin
    int hi, lo;
    tbl[0] = '{1, 0, 16'h0, 16'h0, 0, 0, 0,  0, 8'd0, 0, 16'h0, 16'h0, 2'b00};
    tbl[1] = '{0, 0, 16'h1234, 16'h5678, 1, 1, 0,  0, 8'd0, 0, 16'h0, 16'h0, 2'b00};
    tbl[2] = '{0, 1, 16'hE010, 16'h0500, 1, 0, 0,  1, 8'd1, 1, 16'hE010, 16'h0500, 2'b01};
    tbl[3] = '{0, 1, 16'h1234, 16'h9999, 0, 1, 0,  1, 8'd1, 1, 16'hE010, 16'h0500, 2'b01};
    tbl[4] = '{0, 0, 16'h0, 16'h0, 0, 0, 1,  1, 8'd1, 0, 16'h0, 16'h0, 2'b00};
    tbl[5] = '{0, 1, 16'hAAAA, 16'hBBBB, 0, 1, 0,  1, 8'd1, 0, 16'h0, 16'h0, 2'b00};
    tbl[6] = '{1, 0, 16'h0, 16'h0, 0, 0, 0,  0, 8'd0, 0, 16'h0, 16'h0, 2'b00};
    tbl[7] = '{0, 1, 16'hC0DE, 16'h0042, 1, 1, 1,  1, 8'd1, 1, 16'hC0DE, 16'h0042, 2'b11};
    for (int i = 0; i < 8; i++) begin
      step(tbl[i].r, tbl[i].k, tbl[i].p, tbl[i].a, tbl[i].re, tbl[i].we, tbl[i].lc);
      chk($sformatf("vec%0d", i), dut_vec(),
          {tbl[i].e_rst, tbl[i].e_cnt, tbl[i].e_lv, tbl[i].e_pc, tbl[i].e_addr, tbl[i].e_acc, 1'b0});
    end
    // reset then 50 quiet cycles
    step(1, 0, 16'h0, 16'h0, 0, 0, 0);
    for (int i = 0; i < 50; i++) begin
      idle(16'h0);
      chk("quiet", {35'd0, cpu_rst, viol_cnt, log_valid}, 45'd0);
    end
    // single kill: 16-cycle reset, capture, then return home
    step(0, 1, 16'hE010, 16'h0500, 1, 0, 0);
    chk("log_first", {11'd0, last_pc, last_addr, last_acc}, {11'd0, 16'hE010, 16'h0500, 2'b01});
    chk("cnt_first", {37'd0, viol_cnt}, 45'd1);
    run_hi(hi);
    chk("hold_len", 45'(hi), 45'd16);
    idle(16'h0); idle(16'h0); idle(16'hFFFE);
    run_hi(hi);
    for (int i = 0; i < 300 && !cpu_rst; i++) idle(16'h0);
    chk("home_idle", {44'd0, cpu_rst}, 45'd0);
    // retrigger at cycle 10 of HOLD
    step(1, 0, 16'h0, 16'h0, 0, 0, 0);
    step(0, 1, 16'hE010, 16'h0500, 1, 0, 0);
    for (int i = 0; i < 9; i++) idle(16'h0);
    step(0, 1, 16'h1111, 16'h2222, 0, 1, 0);
    run_hi(hi);
    chk("retrig_len", 45'(hi), 45'd16);
    chk("retrig_cnt", {37'd0, viol_cnt}, 45'd1);
    chk("retrig_log", {11'd0, last_pc, last_addr, last_acc}, {11'd0, 16'hE010, 16'h0500, 2'b01});
    // no return to the handler: retry after the wait budget
    run_lo(lo);
    chk("wait_len", 45'(lo), 45'd256);
    run_hi(hi);
    chk("retry_len", 45'(hi), 45'd16);
    chk("retry_cnt", {37'd0, viol_cnt}, 45'd1);
    // episode counting and log retention
    step(1, 0, 16'h0, 16'h0, 0, 0, 0);
    episode(16'h1000, 16'h2000);
    episode(16'h3000, 16'h4000);
    chk("two_ep", {19'd0, viol_cnt, last_pc, log_valid, 1'b0}, {19'd0, 8'd2, 16'h1000, 1'b1, 1'b0});
    step(0, 0, 16'h0, 16'h0, 0, 0, 1);
    chk("clr", {27'd0, log_valid, last_pc, 1'b0}, 45'd0);
    episode(16'h5000, 16'h6000);
    chk("third_ep", {19'd0, viol_cnt, last_pc, log_valid, 1'b0}, {19'd0, 8'd3, 16'h5000, 1'b1, 1'b0});
    for (int i = 0; i < 300; i++) episode(16'(i), 16'(i * 3));
    chk("saturate", {37'd0, viol_cnt}, 45'd255);
    // random traffic against the model
    step(1, 0, 16'h0, 16'h0, 0, 0, 0);
    for (int i = 0; i < 4000; i++)
      step($urandom_range(0, 599) == 0, $urandom_range(0, 5) == 0,
           ($urandom_range(0, 5) == 0) ? 16'hFFFE : 16'($urandom),
           16'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 39) == 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
